mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the RV32I core. Consumes opcode/funct3 from the field decoder plus

---
 rtl/mc_ctrl_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - RV32I multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) with bus watchdog
// Optional feature macro ILLEGAL_TRAP_EN: illegal opcodes and bus timeouts halt the core in TRAP.
module mc_ctrl_fsm #(
    parameter int WAIT_MAX  = 255,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 br_taken,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int              WW        = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(WAIT_MAX - 1);

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [WW-1:0]        r_wait;
    logic [INSTRET_W-1:0] r_instret;

    logic w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store, w_opimm, w_op, w_misc, w_system;
    logic w_alu_kind, w_mem_kind, w_legal, w_waiting, w_timeout;
    logic w_unused;

    assign w_lui    = (opcode == OP_LUI);
    assign w_auipc  = (opcode == OP_AUIPC);
    assign w_jal    = (opcode == OP_JAL);
    assign w_jalr   = (opcode == OP_JALR);
    assign w_branch = (opcode == OP_BRANCH);
    assign w_load   = (opcode == OP_LOAD);
    assign w_store  = (opcode == OP_STORE);
    assign w_opimm  = (opcode == OP_OPIMM);
    assign w_op     = (opcode == OP_OP);
    assign w_misc   = (opcode == OP_MISC);
    assign w_system = (opcode == OP_SYSTEM);

    assign w_alu_kind = w_lui | w_auipc | w_jal | w_jalr | w_opimm | w_op;
    assign w_mem_kind = w_load | w_store;
    assign w_legal    = w_alu_kind | w_mem_kind | w_branch | w_misc | w_system;

    // funct3 is consumed by the datapath's load/store/branch units only
    assign w_unused = ^funct3;

    // An ack arriving in the cycle the counter reaches its limit takes priority over the timeout
    assign w_waiting = ((r_state == S_FETCH) && !imem_ack) || ((r_state == S_MEM) && !dmem_ack);
    assign w_timeout = w_waiting && (r_wait == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_waiting && !w_timeout)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
            if (retire)
                r_instret <= r_instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (imem_ack)
                    w_next = S_DECODE;
`ifdef ILLEGAL_TRAP_EN
                else if (w_timeout)
                    w_next = S_TRAP;
`endif
            end
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                w_next = w_legal ? S_EXEC : S_TRAP;
`else
                w_next = S_EXEC;
`endif
            end
            S_EXEC: begin
                if (w_mem_kind)
                    w_next = S_MEM;
                else if (w_alu_kind)
                    w_next = S_WB;
                else
                    w_next = S_FETCH;
            end
            S_MEM: begin
                if (dmem_ack)
                    w_next = w_load ? S_WB : S_FETCH;
                else if (w_timeout)
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_next = S_FETCH;
`endif
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        retire    = 1'b0;
        if (!rst) begin
            if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
                alu_a_sel = w_auipc | w_jal | w_branch;
                alu_b_sel = !w_op;
            end
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_EXEC: begin
                    if (w_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? 2'd1 : 2'd0;
                        retire = 1'b1;
                    end else if (!w_mem_kind && !w_alu_kind) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_store;
`ifdef ILLEGAL_TRAP_EN
                    if (dmem_ack && w_store) begin
`else
                    if ((dmem_ack && w_store) || w_timeout) begin
`endif
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    wb_sel = w_lui ? 2'd3 : w_load ? 2'd1 : (w_jal | w_jalr) ? 2'd2 : 2'd0;
                    pc_we  = 1'b1;
                    pc_sel = w_jal ? 2'd1 : w_jalr ? 2'd2 : 2'd0;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign instret = r_instret;

`ifdef ILLEGAL_TRAP_EN
    logic       r_trap;
    logic [1:0] r_cause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trap  <= 1'b0;
            r_cause <= 2'd0;
        end else if (r_state == S_DECODE && !w_legal) begin
            r_trap  <= 1'b1;
            r_cause <= 2'd1;
        end else if (w_timeout) begin
            r_trap  <= 1'b1;
            r_cause <= 2'd2;
        end
    end

    assign trap       = r_trap;
    assign trap_cause = r_cause;
`else
    assign trap       = 1'b0;
    assign trap_cause = 2'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - scoreboard bench for mc_ctrl_fsm with randomized instruction/ack-delay stimulus
module tb_mc_ctrl_fsm;

    localparam int WM = 4;
    localparam int IW = 4;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011, OPI = 7'b0010011;
    localparam logic [6:0] OPR = 7'b0110011, MISC = 7'b0001111, SYS = 7'b1110011;
    localparam logic [6:0] OPS [14] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, MISC, SYS,
                                        7'h7F, 7'h00, 7'h0B};

    logic          clk, rst, br_taken, imem_ack, dmem_ack;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, retire, trap;
    logic [1:0]    pc_sel, wb_sel, trap_cause;
    logic [2:0]    state;
    logic [IW-1:0] instret;

    mc_ctrl_fsm #(.WAIT_MAX(WM), .INSTRET_W(IW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .rf_we(rf_we), .wb_sel(wb_sel), .state(state), .retire(retire),
        .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    typedef struct {
        int lat; int st; int ps; int rf; int wb; int a; int b; int dreq; int dwe; int ireq; int inst;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   issued = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one instruction from its class and the bus delays applied to it
    function automatic exp_t model(logic [6:0] op, bit br, int fd, int md, int cnt);
        exp_t e;
        bit is_ld, is_st, is_br, is_alu, mto;
        int f, m;
        is_ld  = (op == LD);
        is_st  = (op == ST);
        is_br  = (op == BR);
        is_alu = (op == LUI) || (op == AUIPC) || (op == JAL) || (op == JALR) || (op == OPI) || (op == OPR);
        f   = fd + 1;
        mto = (md >= WM);
        m   = mto ? WM : md + 1;
        e.ireq = f;
        e.dreq = (is_ld || is_st) ? m : 0;
        e.dwe  = is_st;
        e.a    = (op == AUIPC) || (op == JAL) || is_br;
        e.b    = (op != OPR);
        e.ps   = is_br ? int'(br) : (op == JAL) ? 1 : (op == JALR) ? 2 : 0;
        e.rf   = is_alu || (is_ld && !mto);
        e.wb   = (op == LUI) ? 3 : is_ld ? 1 : ((op == JAL) || (op == JALR)) ? 2 : 0;
        if (is_alu) begin
            e.lat = f + 3; e.st = 4;
        end else if (is_st) begin
            e.lat = f + 2 + m; e.st = 3;
        end else if (is_ld) begin
            e.lat = f + 2 + m + (mto ? 0 : 1); e.st = mto ? 3 : 4;
        end else begin
            e.lat = f + 2; e.st = 2;
        end
        e.inst = cnt % (1 << IW);
        return e;
    endfunction

    // Issue one instruction; entered and left aligned to a falling clock edge
    task automatic run(logic [6:0] op, bit br, int fd, int md);
        int fc, mc;
        bit done;
        issued++;
        q.push_back(model(op, br, fd, md, issued));
        opcode = op; br_taken = br; funct3 = 3'($urandom);
        fc = 0; mc = 0; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            imem_ack = imem_req && (fc == fd);
            if (imem_req && !imem_ack) fc++;
            dmem_ack = dmem_req && (mc == md);
            if (dmem_req) mc++;
            #1;
            if (retire) done = 1;
            else @(negedge clk);
        end
        if (!done) check("stim_retire_timeout", 0, 1);
        @(negedge clk);
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issued = 0;
    endtask

    // Monitor: tallies each instruction's activity and checks it against the scoreboard at retire
    initial begin
        int cyc, ireq, dreq, irwe, av, bv, pinst;
        bit dwe_bad, stray, pend;
        exp_t e;
        cyc = 0; ireq = 0; dreq = 0; irwe = 0; av = 0; bv = 0; pinst = 0;
        dwe_bad = 0; stray = 0; pend = 0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                cyc = 0; ireq = 0; dreq = 0; irwe = 0; dwe_bad = 0; stray = 0; pend = 0;
                continue;
            end
            if (pend) begin
                check("instret", 32'(instret), pinst);
                pend = 0;
            end
            cyc++;
            if (imem_req) ireq++;
            if (ir_we) irwe++;
            if (dmem_req) begin
                dreq++;
                if (q.size() > 0 && int'(dmem_we) != q[0].dwe) dwe_bad = 1;
            end
            if (state == 3'd2) begin av = alu_a_sel; bv = alu_b_sel; end
            if (!retire && (rf_we || pc_we)) stray = 1;
            if (retire) begin
                if (q.size() == 0) begin
                    check("unexpected_retire", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("latency", cyc, e.lat);
                    check("retire_state", 32'(state), e.st);
                    check("pc_we", 32'(pc_we), 1);
                    check("pc_sel", 32'(pc_sel), e.ps);
                    check("rf_we", 32'(rf_we), e.rf);
                    if (e.rf != 0) check("wb_sel", 32'(wb_sel), e.wb);
                    check("alu_a_sel", av, e.a);
                    check("alu_b_sel", bv, e.b);
                    check("dmem_req_cycles", dreq, e.dreq);
                    check("dmem_we_bad", 32'(dwe_bad), 0);
                    check("imem_req_cycles", ireq, e.ireq);
                    check("ir_we_count", irwe, 1);
                    check("stray_strobe", 32'(stray), 0);
                    check("trap_at_retire", {trap, trap_cause}, 0);
                    pinst = e.inst;
                    pend  = 1;
                end
                cyc = 0; ireq = 0; dreq = 0; irwe = 0; dwe_bad = 0; stray = 0;
            end else if (cyc > 400) begin
                check("monitor_watchdog", 0, 1);
                cyc = 0;
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #3;
        check("rst_strobes", {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, trap}, 0);
        check("rst_muxes", {pc_sel, wb_sel, trap_cause}, 0);
        check("rst_state", 32'(state), 0);
        check("rst_instret", 32'(instret), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run(OPR, 0, 0, 0);
        run(LD, 0, 0, 3);
        run(BR, 1, 0, 0);
        run(BR, 0, 0, 0);
        run(ST, 0, 0, WM - 1);
`ifndef ILLEGAL_TRAP_EN
        run(7'h7F, 0, 0, 0);
        run(OPR, 0, WM - 1, 0);
        run(OPI, 0, 10, 0);
        run(ST, 0, 0, WM);
        run(LD, 0, 0, WM + 2);
        for (int i = 0; i < 60; i++)
            run(OPS[$urandom_range(13, 0)], 1'($urandom), $urandom_range(7, 0), $urandom_range(6, 0));
`else
        for (int i = 0; i < 60; i++)
            run(OPS[$urandom_range(10, 0)], 1'($urandom), $urandom_range(WM - 1, 0),
                $urandom_range(WM - 1, 0));
`endif

        // Reset while a store is waiting in MEM
        opcode = ST;
        #1 imem_ack = 1'b1;
        @(negedge clk); #1 imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("mid_rst_dmem_req_before", 32'(dmem_req), 1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_strobes", {imem_req, dmem_req, pc_we, rf_we, retire}, 0);
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_instret", 32'(instret), 0);
        @(negedge clk);
        rst = 1'b0;
        issued = 0;
        run(OPR, 0, 0, 0);
        run(JALR, 0, 1, 0);

`ifdef ILLEGAL_TRAP_EN
        opcode = 7'h7F;
        #1 imem_ack = 1'b1;
        @(negedge clk); #1 imem_ack = 1'b0;
        @(negedge clk); #1;
        check("illegal_state", 32'(state), 5);
        check("illegal_trap", {trap, trap_cause}, 3'b101);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("trap_idle", {imem_req, dmem_req, retire, pc_we, rf_we}, 0);
        end
        do_reset();
        opcode = OPR;
        for (int i = 0; i < WM; i++) begin
            #1 check("to_fetching", {state, imem_req}, 4'b0001);
            @(negedge clk);
        end
        #1;
        check("to_state", 32'(state), 5);
        check("to_trap", {trap, trap_cause}, 3'b110);
        check("to_imem_req", 32'(imem_req), 0);
        @(negedge clk);
        do_reset();
        run(LUI, 0, WM - 1, 0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
